// File: rtl/scan_sram_sequencer.sv
// Front-end for the two-phase scan chain and SRAM macro. One command becomes a scan load,
// one SRAM access and, for reads, a capture plus serial unload. It also generates sclka/sclkb.
module scan_sram_sequencer #(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WMASK_WIDTH = 4,
  parameter int unsigned PH_CYC      = 2,
  parameter int unsigned GAP_CYC     = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [DATA_WIDTH-1:0]  cmd_wdata,
  input  logic [WMASK_WIDTH-1:0] cmd_wmask,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   sclka,
  output logic                   sclkb,
  output logic                   scan_in,
  output logic                   scan_enable,
  output logic                   scan_mode,
  output logic                   csb,
  output logic                   web,
  output logic [WMASK_WIDTH-1:0] wmask,
  input  logic                   scan_out
);

  localparam int unsigned W    = ADDR_WIDTH + 2 * DATA_WIDTH;
  localparam int unsigned T    = 2 * (PH_CYC + GAP_CYC);
  localparam int unsigned PhW  = $clog2(T);
  localparam int unsigned CntW = $clog2(W + 1);

  // Tick layout: pos 0 gap (outputs update here), A, gap, B, remaining GAP_CYC-1 gap cycles.
  localparam logic [PhW-1:0]  PhLast  = PhW'(T - 1);
  localparam logic [PhW-1:0]  AFirst  = PhW'(1);
  localparam logic [PhW-1:0]  ALast   = PhW'(PH_CYC);
  localparam logic [PhW-1:0]  BFirst  = PhW'(PH_CYC + GAP_CYC + 1);
  localparam logic [PhW-1:0]  BLast   = PhW'(2 * PH_CYC + GAP_CYC);
  localparam logic [CntW-1:0] CntLast = CntW'(W);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StAccess,
    StCapture,
    StUnload,
    StResp
  } state_e;

  state_e                 state_q;
  logic [PhW-1:0]         ph_q;
  logic [PhW-1:0]         ph_nxt;
  logic [CntW-1:0]        cnt_q;
  logic [W-1:0]           sr_q;
  logic [W-1:0]           sr_rot;
  logic [DATA_WIDTH-1:0]  rdata_shift;
  logic                   write_q;
  logic [WMASK_WIDTH-1:0] wmask_q;
  logic                   active;
  logic                   wrap;

  assign scan_mode = 1'b1;

  always_comb begin
    active      = (state_q != StIdle) && (state_q != StResp);
    wrap        = (ph_q == PhLast);
    ph_nxt      = wrap ? '0 : ph_q + 1'b1;
    // Rotating keeps V intact for the re-shift during unload.
    sr_rot      = {sr_q[W-2:0], sr_q[W-1]};
    rdata_shift = {rsp_rdata[DATA_WIDTH-2:0], scan_out};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ph_q        <= '0;
      cnt_q       <= '0;
      sr_q        <= '0;
      write_q     <= 1'b0;
      wmask_q     <= '0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      sclka       <= 1'b0;
      sclkb       <= 1'b0;
      scan_in     <= 1'b0;
      scan_enable <= 1'b0;
      csb         <= 1'b1;
      web         <= 1'b1;
      wmask       <= '0;
    end else begin
      sclka <= active && (ph_nxt >= AFirst) && (ph_nxt <= ALast);
      sclkb <= active && (ph_nxt >= BFirst) && (ph_nxt <= BLast);
      if (active) ph_q <= ph_nxt;

      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            state_q   <= StLoad;
            cmd_ready <= 1'b0;
            sr_q      <= {cmd_addr, cmd_wdata, {DATA_WIDTH{1'b0}}};
            write_q   <= cmd_write;
            wmask_q   <= cmd_wmask;
            cnt_q     <= '0;
            // One settle cycle before the first tick's update slot.
            ph_q      <= PhLast;
          end
        end

        StLoad, StUnload: begin
          if (wrap) begin
            if (cnt_q == CntLast) begin
              scan_enable <= 1'b0;
              scan_in     <= 1'b0;
              if (state_q == StLoad) begin
                state_q <= StAccess;
                csb     <= 1'b0;
                web     <= ~write_q;
                wmask   <= write_q ? wmask_q : '0;
              end else begin
                state_q   <= StResp;
                rsp_valid <= 1'b1;
              end
            end else begin
              scan_enable <= 1'b1;
              scan_in     <= sr_q[W-1];
              sr_q        <= sr_rot;
              cnt_q       <= cnt_q + 1'b1;
              if (state_q == StUnload) rsp_rdata <= rdata_shift;
            end
          end
        end

        StAccess: begin
          if (wrap) begin
            csb   <= 1'b1;
            web   <= 1'b1;
            wmask <= '0;
            if (write_q) begin
              state_q   <= StIdle;
              cmd_ready <= 1'b1;
            end else begin
              state_q <= StCapture;
            end
          end
        end

        StCapture: begin
          // This slot precedes the first unload A rise, so it takes the first scan_out sample.
          if (wrap) begin
            state_q     <= StUnload;
            cnt_q       <= CntW'(1);
            scan_enable <= 1'b1;
            scan_in     <= sr_q[W-1];
            sr_q        <= sr_rot;
            rsp_rdata   <= rdata_shift;
          end
        end

        StResp: begin
          if (rsp_ready) begin
            state_q   <= StIdle;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sram_sequencer.sv
// Bench for scan_sram_sequencer: pin-level chain/SRAM environment plus a word-level
// memory reference model, with directed and random read/write commands.
module tb_scan_sram_sequencer;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int W  = AW + 2 * DW;
  localparam int T  = 6;

  logic          clk, rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [MW-1:0] cmd_wmask;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          sclka, sclkb, scan_in, scan_enable, scan_mode, csb, web, scan_out;
  logic [MW-1:0] wmask;

  scan_sram_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_wmask  (cmd_wmask),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .sclka      (sclka),
    .sclkb      (sclkb),
    .scan_in    (scan_in),
    .scan_enable(scan_enable),
    .scan_mode  (scan_mode),
    .csb        (csb),
    .web        (web),
    .wmask      (wmask),
    .scan_out   (scan_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Environment: two-phase register chain (master on A, slave on B) and SRAM clocked by A.
  logic [W-1:0]  ch_m, ch_s, acc_vec;
  logic [DW-1:0] sram [16];
  logic [DW-1:0] sram_dout;
  int            n_access = 0;
  int            a_shift  = 0;

  always @(posedge sclka) begin
    ch_m <= scan_enable ? {ch_s[W-2:0], scan_in} : {ch_s[W-1:DW], sram_dout};
    if (scan_enable) a_shift <= a_shift + 1;
    if (!csb) begin
      n_access <= n_access + 1;
      acc_vec  <= ch_s;
      if (!web) sram[ch_s[W-1 -: AW]] <= merge(sram[ch_s[W-1 -: AW]], ch_s[2*DW-1:DW], wmask);
      else      sram_dout <= sram[ch_s[W-1 -: AW]];
    end
  end

  always @(posedge sclkb) ch_s <= ch_m;

  assign scan_out = ch_s[W-1];

  // Pin-protocol monitors.
  int   ovl = 0, chg = 0, n_acc = 0;
  logic p_si, p_csb, p_web;

  always @(negedge clk) begin
    if (rst_n) begin
      if (sclka && sclkb) ovl <= ovl + 1;
      if (((scan_in !== p_si) || (csb !== p_csb) || (web !== p_web)) && (sclka || sclkb))
        chg <= chg + 1;
    end
    p_si  <= scan_in;
    p_csb <= csb;
    p_web <= web;
  end

  always @(posedge clk) if (rst_n && cmd_valid && cmd_ready) n_acc <= n_acc + 1;

  // Reference model: word memory with byte-masked writes.
  logic [DW-1:0] exp_mem [16];
  logic [15:0]   exp_vld;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_clk"}, {sclka, sclkb}, 2'b00);
    check_eq({tag, "_scan"}, {scan_in, scan_enable, scan_mode}, 3'b001);
    check_eq({tag, "_sram"}, {csb, web, wmask}, {2'b11, 4'h0});
    check_eq({tag, "_hs"}, {cmd_ready, rsp_valid}, 2'b10);
    check_eq({tag, "_rdata"}, rsp_rdata, 32'h0);
  endtask

  task automatic do_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [MW-1:0] m, input int hold, input logic keep,
                        output logic [DW-1:0] rd);
    int            t, acc_cyc, n0;
    logic [DW-1:0] held;
    logic          bad;
    rd = '0;
    t  = 0;
    while (!cmd_ready && t < 4000) begin @(negedge clk); t++; end
    n0        = n_access;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wmask = m;
    @(posedge clk);
    #1 acc_cyc = cyc;
    @(negedge clk);
    if (!keep) cmd_valid = 1'b0;
    t = 0;
    if (wr) begin
      while (!cmd_ready && t < 2000) begin @(negedge clk); t++; end
      check_eq("wr_latency", cyc - acc_cyc, (W + 1) * T + 1);
      exp_mem[a] = merge(exp_mem[a], d, m);
      exp_vld[a] = 1'b1;
    end else begin
      while (!rsp_valid && t < 2000) begin @(negedge clk); t++; end
      check_eq("rd_latency", cyc - acc_cyc, (2 * W + 2) * T + 1);
      check_eq("rd_data", rsp_rdata, exp_mem[a]);
      rd   = rsp_rdata;
      held = rsp_rdata;
      bad  = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        if (!rsp_valid || rsp_rdata !== held) bad = 1'b1;
      end
      check_eq("rsp_hold", bad, 1'b0);
      rsp_ready = 1'b1;
      cmd_valid = 1'b0;
      @(negedge clk);
      rsp_ready = 1'b0;
      check_eq("rsp_release", {rsp_valid, cmd_ready}, 2'b01);
    end
    check_eq("access_cnt", n_access - n0, 1);
    check_eq("load_vec", acc_vec, {a, d, 32'h0});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd;
    logic [AW-1:0] a;
    logic [MW-1:0] m;
    logic          wr;
    int            t, n0, a0;

    exp_vld   = '0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wmask = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;
    @(negedge clk);

    do_cmd(1'b1, 4'd5, 32'hDEADBEEF, 4'hF, 0, 1'b0, rd);
    do_cmd(1'b0, 4'd5, $urandom, 4'h0, 3, 1'b0, rd);
    check_eq("rd_deadbeef", rd, 32'hDEADBEEF);

    do_cmd(1'b1, 4'd3, 32'hFFFFFFFF, 4'hF, 0, 1'b0, rd);
    do_cmd(1'b1, 4'd3, 32'h11223344, 4'b0101, 0, 1'b0, rd);
    do_cmd(1'b0, 4'd3, $urandom, 4'h0, 1, 1'b0, rd);
    check_eq("mask_merge", rd, 32'hFF22FF44);

    // Abort a write to addr 5 partway through its load.
    while (!cmd_ready) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 4'd5;
    cmd_wdata = 32'h12345678;
    cmd_wmask = 4'hF;
    a0        = a_shift;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while ((a_shift - a0) < 20 && t < 2000) begin @(negedge clk); t++; end
    check_eq("reach_bit20", a_shift - a0, 20);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_cmd(1'b0, 4'd5, $urandom, 4'h0, 2, 1'b0, rd);
    check_eq("rd_after_abort", rd, 32'hDEADBEEF);

    n0 = n_acc;
    do_cmd(1'b0, 4'd3, $urandom, 4'h0, 10, 1'b1, rd);
    check_eq("single_accept", n_acc - n0, 1);

    for (int i = 0; i < 10; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 15));
      m  = 4'($urandom_range(0, 15));
      if (!wr && !exp_vld[a]) a = 4'd5;
      if (wr && !exp_vld[a]) m = 4'hF;
      do_cmd(wr, a, $urandom, m, $urandom_range(0, 3), 1'b0, rd);
    end

    check_eq("clk_overlap", ovl, 0);
    check_eq("chg_while_clk_high", chg, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
